// File: rtl/plane_mixer.sv
// Pixel priority mixer and shared palette stage: resolves FX/SPR/VA/VB to a palette
// index once per V6M period and time-multiplexes a 2 KB palette RAM with CPU accesses.
module plane_mixer (
  input  logic        clk_main,
  input  logic        reset,
  input  logic        V6M,
  input  logic [11:0] VA,
  input  logic [11:0] VB,
  input  logic [7:0]  FX,
  input  logic [7:0]  SPR,
  input  logic        PRI,
  input  logic        NCBLK,
  input  logic        PAL_CS,
  input  logic        NREAD,
  input  logic [10:0] AB,
  input  logic [7:0]  DB_IN,
  output logic [7:0]  DB_OUT,
  output logic        DB_DIR,
  output logic        PAL_DTACK,
  output logic [4:0]  R,
  output logic [4:0]  G,
  output logic [4:0]  B
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_RDATA,
    ST_ACK,
    ST_HOLD
  } cpu_state_t;

  logic       r_v6m_q1;
  logic       r_v6m_q2;
  logic [1:0] r_phase;
  logic       w_edge;
  logic [1:0] w_slot;

  logic [9:0] w_idx;
  logic [9:0] r_idx;
  logic       r_blk;
  logic       r_pix_live;
  logic [7:0] r_hi;
  logic [4:0] r_r;
  logic [4:0] r_g;
  logic [4:0] r_b;

  logic [7:0]  r_pal [0:2047];
  logic [7:0]  r_ram_q;
  logic [10:0] w_addr;
  logic        w_we;
  logic        w_cpu_slot;

  cpu_state_t r_state;
  cpu_state_t w_state_next;
  logic        r_cs_prev;
  logic        w_cs_fall;
  logic [10:0] r_ab;
  logic [7:0]  r_db;
  logic        r_rd;
  logic        r_dtack;
  logic [7:0]  r_db_out;
  logic        r_db_dir;

  // Upper bits of the scroll-layer pixels carry nothing for this stage.
  logic w_unused;
  assign w_unused = ^{VA[11:8], VB[11:8]};

  // A V6M rising edge always marks slot 0; otherwise the counter free-runs.
  assign w_edge = r_v6m_q1 & ~r_v6m_q2;
  assign w_slot = w_edge ? S0 : r_phase;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_v6m_q1 <= 1'b0;
      r_v6m_q2 <= 1'b0;
      r_phase  <= S0;
    end else begin
      r_v6m_q1 <= V6M;
      r_v6m_q2 <= r_v6m_q1;
      r_phase  <= w_slot + 2'd1;
    end
  end

  always_comb begin
    w_idx = {2'b10, VB[7:0]};
    if (FX[3:0] != 4'd0) begin
      w_idx = {2'b00, FX};
    end else if (PRI) begin
      if (VA[3:0] != 4'd0)       w_idx = {2'b01, VA[7:0]};
      else if (SPR[3:0] != 4'd0) w_idx = {2'b11, SPR};
    end else begin
      if (SPR[3:0] != 4'd0)      w_idx = {2'b11, SPR};
      else if (VA[3:0] != 4'd0)  w_idx = {2'b01, VA[7:0]};
    end
  end

  // Only a real V6M edge starts a pixel, so a stalled V6M leaves R/G/B frozen.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_idx      <= 10'd0;
      r_blk      <= 1'b0;
      r_pix_live <= 1'b0;
      r_hi       <= 8'd0;
      r_r        <= 5'd0;
      r_g        <= 5'd0;
      r_b        <= 5'd0;
    end else begin
      if (w_edge) begin
        r_idx      <= w_idx;
        r_blk      <= ~NCBLK;
        r_pix_live <= 1'b1;
      end
      if (w_slot == S2) begin
        r_hi <= r_ram_q;
      end
      if (w_slot == S3 && r_pix_live) begin
        r_pix_live <= 1'b0;
        r_r <= r_blk ? 5'd0 : r_ram_q[4:0];
        r_g <= r_blk ? 5'd0 : {r_hi[1:0], r_ram_q[7:5]};
        r_b <= r_blk ? 5'd0 : r_hi[6:2];
      end
    end
  end

  // Slot 1 reads the high byte, slot 2 the low byte, slot 3 belongs to the CPU.
  assign w_cpu_slot = (w_slot == S3) && (r_state == ST_PEND);
  assign w_addr     = w_cpu_slot ? r_ab : {r_idx, (w_slot == S2)};
  assign w_we       = w_cpu_slot & ~r_rd;

  always_ff @(posedge clk_main) begin
    if (w_we) begin
      r_pal[w_addr] <= r_db;
    end
    r_ram_q <= r_pal[w_addr];
  end

  assign w_cs_fall = ~PAL_CS & r_cs_prev;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall) w_state_next = ST_PEND;
      ST_PEND:  if (w_slot == S3) w_state_next = r_rd ? ST_RDATA : ST_ACK;
      ST_RDATA: w_state_next = ST_ACK;
      ST_ACK:   w_state_next = PAL_CS ? ST_IDLE : ST_HOLD;
      ST_HOLD:  if (PAL_CS) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // r_cs_prev resets low so a select held across reset is not a new request.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cs_prev <= 1'b0;
      r_ab      <= 11'd0;
      r_db      <= 8'd0;
      r_rd      <= 1'b0;
      r_dtack   <= 1'b1;
      r_db_out  <= 8'd0;
      r_db_dir  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cs_prev <= PAL_CS;
      r_dtack   <= (w_state_next != ST_HOLD);
      r_db_dir  <= ~PAL_CS & ~NREAD;
      if (r_state == ST_IDLE && w_cs_fall) begin
        r_ab <= AB;
        r_db <= DB_IN;
        r_rd <= ~NREAD;
      end
      if (r_state == ST_RDATA) begin
        r_db_out <= r_ram_q;
      end
    end
  end

  assign R         = r_r;
  assign G         = r_g;
  assign B         = r_b;
  assign DB_OUT    = r_db_out;
  assign DB_DIR    = r_db_dir;
  assign PAL_DTACK = r_dtack;

endmodule

// File: tb/tb_plane_mixer.sv
// Scoreboard bench for plane_mixer: stimulus queues expected pixels and CPU acks,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_plane_mixer;

  logic        clk_main = 1'b0;
  logic        reset    = 1'b1;
  logic        V6M      = 1'b0;
  logic [11:0] VA       = 12'h000;
  logic [11:0] VB       = 12'h000;
  logic [7:0]  FX       = 8'h00;
  logic [7:0]  SPR      = 8'h00;
  logic        PRI      = 1'b0;
  logic        NCBLK    = 1'b1;
  logic        PAL_CS   = 1'b1;
  logic        NREAD    = 1'b1;
  logic [10:0] AB       = 11'h000;
  logic [7:0]  DB_IN    = 8'h00;
  logic [7:0]  DB_OUT;
  logic        DB_DIR;
  logic        PAL_DTACK;
  logic [4:0]  R;
  logic [4:0]  G;
  logic [4:0]  B;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          due;
    logic [14:0] rgb;
  } pix_exp_t;

  typedef struct {
    logic        rd;
    logic [7:0]  data;
    logic [10:0] addr;
  } cpu_exp_t;

  pix_exp_t pix_q[$];
  cpu_exp_t cpu_q[$];
  pix_exp_t mp;
  cpu_exp_t mc;
  logic     prev_dtack = 1'b1;

  plane_mixer dut (
    .clk_main (clk_main),
    .reset    (reset),
    .V6M      (V6M),
    .VA       (VA),
    .VB       (VB),
    .FX       (FX),
    .SPR      (SPR),
    .PRI      (PRI),
    .NCBLK    (NCBLK),
    .PAL_CS   (PAL_CS),
    .NREAD    (NREAD),
    .AB       (AB),
    .DB_IN    (DB_IN),
    .DB_OUT   (DB_OUT),
    .DB_DIR   (DB_DIR),
    .PAL_DTACK(PAL_DTACK),
    .R        (R),
    .G        (G),
    .B        (B)
  );

  always #5 clk_main = ~clk_main;

  // V6M: high for two clocks, low for two; slot 0 lands on edges with cyc%4==2
  initial begin
    forever begin
      @(posedge clk_main);
      cyc = cyc + 1;
      #1 V6M = (cyc % 4 == 0) || (cyc % 4 == 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_slot(input int res);
    do begin
      @(posedge clk_main);
      #1;
    end while (cyc % 4 != res);
  endtask

  // Inputs set right after an s3 edge are sampled at the next s0; colour lands 4 edges later.
  task automatic pixel(input logic [11:0] va, input logic [11:0] vb, input logic [7:0] fx,
                       input logic [7:0] spr, input logic pri, input logic ncblk,
                       input logic [4:0] er, input logic [4:0] eg, input logic [4:0] eb);
    wait_slot(1);
    VA = va; VB = vb; FX = fx; SPR = spr; PRI = pri; NCBLK = ncblk;
    pix_q.push_back('{cyc + 4, {er, eg, eb}});
    pix_q.push_back('{cyc + 7, {er, eg, eb}});
  endtask

  task automatic cpu_access(input logic rd, input logic [10:0] addr, input logic [7:0] data,
                            input int res, input int exp_lat, input int hold);
    int  start;
    bit  seen;
    wait_slot(res);
    cpu_q.push_back('{rd, data, addr});
    AB = addr; DB_IN = rd ? 8'h00 : data; NREAD = ~rd; PAL_CS = 1'b0;
    start = cyc;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_main);
      #1;
      if (PAL_DTACK == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk(rd ? "rd_ack_latency" : "wr_ack_latency", seen ? (cyc - start) : -1, exp_lat);
    repeat (hold) begin
      @(posedge clk_main);
      #1;
    end
    PAL_CS = 1'b1;
    NREAD  = 1'b1;
    @(negedge clk_main);
    chk("dtack_held_until_edge", PAL_DTACK, 1'b0);
    @(posedge clk_main);
    #1;
    chk("dtack_release", PAL_DTACK, 1'b1);
  endtask

  always @(negedge clk_main) begin
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      mp = pix_q.pop_front();
      $display("pix cyc=%0d rgb=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc, R, G, B,
               mp.rgb[14:10], mp.rgb[9:5], mp.rgb[4:0]);
      chk("pixel_rgb", {R, G, B}, mp.rgb);
    end
    if (PAL_DTACK == 1'b0 && prev_dtack == 1'b1) begin
      chk("ack_expected", cpu_q.size() > 0, 1'b1);
      if (cpu_q.size() > 0) begin
        mc = cpu_q.pop_front();
        $display("cpu cyc=%0d %s addr=0x%03h db_out=0x%02h db_dir=%0b", cyc,
                 mc.rd ? "rd" : "wr", mc.addr, DB_OUT, DB_DIR);
        if (mc.rd) chk("read_data", DB_OUT, mc.data);
        chk("db_dir", DB_DIR, mc.rd);
      end
    end
    prev_dtack = PAL_DTACK;
  end

  initial begin
    bit seen_ack;
    repeat (3) @(posedge clk_main);
    #1;
    chk("reset_R", R, 5'd0);
    chk("reset_G", G, 5'd0);
    chk("reset_B", B, 5'd0);
    chk("reset_DB_OUT", DB_OUT, 8'h00);
    chk("reset_DB_DIR", DB_DIR, 1'b0);
    chk("reset_DTACK", PAL_DTACK, 1'b1);
    reset = 1'b0;
    repeat (8) @(posedge clk_main);

    // CPU write/read: second write arrives exactly at s3 and waits a full pixel
    cpu_access(1'b0, 11'h024, 8'h7C, 1, 5, 0);
    cpu_access(1'b0, 11'h025, 8'h1F, 0, 6, 0);
    cpu_access(1'b1, 11'h024, 8'h7C, 1, 6, 0);
    cpu_access(1'b1, 11'h025, 8'h1F, 1, 6, 1);

    // Palette entries: 0x112=7C1F, 0x3C5=2C6A, 0x2A0=1234, 0x031=5A5A
    cpu_access(1'b0, 11'h224, 8'h7C, 1, 5, 0);
    cpu_access(1'b0, 11'h225, 8'h1F, 1, 5, 0);
    cpu_access(1'b0, 11'h78A, 8'h2C, 1, 5, 0);
    cpu_access(1'b0, 11'h78B, 8'h6A, 1, 5, 0);
    cpu_access(1'b0, 11'h540, 8'h12, 1, 5, 0);
    cpu_access(1'b0, 11'h541, 8'h34, 1, 5, 0);
    cpu_access(1'b0, 11'h062, 8'h5A, 1, 5, 0);
    cpu_access(1'b0, 11'h063, 8'h5A, 1, 5, 0);

    pixel(12'h012, 12'h003, 8'h00, 8'hC5, 1'b1, 1'b1, 5'd31, 5'd0,  5'd31);
    pixel(12'h012, 12'h003, 8'h00, 8'hC5, 1'b0, 1'b1, 5'd10, 5'd3,  5'd11);
    pixel(12'h010, 12'h0A0, 8'h00, 8'h50, 1'b0, 1'b1, 5'd20, 5'd17, 5'd4);
    pixel(12'h012, 12'h003, 8'h31, 8'hC5, 1'b1, 1'b1, 5'd26, 5'd18, 5'd22);
    pixel(12'h012, 12'h003, 8'h00, 8'hC5, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0);
    pixel(12'h012, 12'h003, 8'h00, 8'hC5, 1'b1, 1'b1, 5'd31, 5'd0,  5'd31);

    // Low byte of entry 0x112 cleared while the same entry streams
    fork
      begin
        pixel(12'h012, 12'h003, 8'h00, 8'hC5, 1'b1, 1'b1, 5'd31, 5'd0, 5'd31);
        pixel(12'h012, 12'h003, 8'h00, 8'hC5, 1'b1, 1'b1, 5'd0,  5'd0, 5'd31);
        pixel(12'h012, 12'h003, 8'h00, 8'hC5, 1'b1, 1'b1, 5'd0,  5'd0, 5'd31);
      end
      begin
        cpu_access(1'b0, 11'h225, 8'h00, 1, 5, 8);
      end
    join
    repeat (10) @(posedge clk_main);

    // Reset in the middle of a pending read
    wait_slot(1);
    AB = 11'h024; NREAD = 1'b0; PAL_CS = 1'b0;
    @(posedge clk_main);
    #1;
    @(posedge clk_main);
    #1;
    chk("pre_reset_db_dir", DB_DIR, 1'b1);
    reset = 1'b1;
    #1;
    chk("midreset_R", R, 5'd0);
    chk("midreset_G", G, 5'd0);
    chk("midreset_B", B, 5'd0);
    chk("midreset_DB_OUT", DB_OUT, 8'h00);
    chk("midreset_DB_DIR", DB_DIR, 1'b0);
    chk("midreset_DTACK", PAL_DTACK, 1'b1);
    repeat (3) @(posedge clk_main);
    #1;
    reset = 1'b0;
    seen_ack = 1'b0;
    repeat (16) begin
      @(negedge clk_main);
      if (PAL_DTACK == 1'b0) seen_ack = 1'b1;
    end
    chk("no_stale_ack", seen_ack, 1'b0);
    PAL_CS = 1'b1;
    NREAD  = 1'b1;
    repeat (12) @(posedge clk_main);

    // Palette survives reset
    pixel(12'h012, 12'h003, 8'h31, 8'hC5, 1'b1, 1'b1, 5'd26, 5'd18, 5'd22);

    for (int i = 0; i < 40; i++) begin
      if (pix_q.size() == 0 && cpu_q.size() == 0) break;
      @(posedge clk_main);
    end
    chk("pix_queue_drained", pix_q.size(), 0);
    chk("cpu_queue_drained", cpu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
